seq_divider: RTL

Iterative unsigned radix-2 restoring divider, the inverse arithmetic unit to the Dadda multiplier datapath. It computes one quotient bit per clock and takes operands and returns results over valid/ready handshakes. It sits beside the multiplier in the arithmetic cluster and trades latency for area: a single WIDTH+1-bit subtractor, with no array.

---
 rtl/seq_divider.sv | 101 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, operands and
// results exchanged over valid/ready handshakes.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] dvsr;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   sub;
  logic             borrow;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // The partial remainder is always below the divisor, so it fits in WIDTH bits
  // and the shifted value stays below 2*divisor. Under that bound the MSB of the
  // WIDTH+1-bit difference is exactly the borrow, i.e. the "r' < divisor" test.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    sub     = r_shift - {1'b0, dvsr};
    borrow  = sub[WIDTH];
    r_next  = borrow ? r_shift[WIDTH-1:0] : sub[WIDTH-1:0];
    q_next  = {q[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            in_ready <= 1'b0;
            q        <= dividend;
            dvsr     <= divisor;
            r        <= '0;
            if (divisor != '0) begin
              state <= RUN;
              count <= CNT_W'(WIDTH - 1);
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          q <= q_next;
          r <= r_next;
          if (count == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
